// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: pixel tick and irq compare line in,
// syncs, coordinates, event pulses and frame count out.
interface vga_timing_gen_if #(
    parameter int CW = 10,
    parameter int FW = 8
);
    logic          pix_en;
    logic [CW-1:0] irq_line;
    logic          hsync;
    logic          vsync;
    logic          active;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          line_start;
    logic          frame_start;
    logic          line_irq;
    logic [FW-1:0] frame_cnt;

    modport master (
        input  pix_en, irq_line,
        output hsync, vsync, active, x, y,
        output line_start, frame_start, line_irq, frame_cnt
    );

    modport slave (
        output pix_en, irq_line,
        input  hsync, vsync, active, x, y,
        input  line_start, frame_start, line_irq, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA-class raster timing generator.
// Outputs are registered decodes of the counters, one tick behind them.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 10,
    parameter int FW       = 8
) (
    input  logic              clk,
    input  logic              reset,
    vga_timing_gen_if.master  bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int MAX_T   = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
    localparam longint CAP = 64'd1 << CW;

    localparam int HS_BEG = H_ACTIVE + H_FP;
    localparam int HS_END = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_BEG = V_ACTIVE + V_FP;
    localparam int VS_END = V_ACTIVE + V_FP + V_SYNC;

    if (H_SYNC == 0 || V_SYNC == 0 || H_ACTIVE == 0 || V_ACTIVE == 0)
    begin : g_bad_timing
        $error("vga_timing_gen: zero sync or active interval");
    end

    if (CAP < longint'(MAX_T)) begin : g_bad_cw
        $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
    end

    logic [CW-1:0] hc_q, hc_d;
    logic [CW-1:0] vc_q, vc_d;
    logic [CW-1:0] x_q, y_q;
    logic          active_q, active_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          ls_q, ls_d;
    logic          fs_q, fs_d;
    logic          li_q, li_d;
    logic [FW-1:0] fc_q, fc_d;
    logic          hc_last, vc_last;
    logic [31:0]   hc32, vc32;

    // Next counter values and decode of the current raster position
    always_comb begin
        hc32     = 32'(hc_q);
        vc32     = 32'(vc_q);
        hc_last  = (hc32 == H_TOTAL - 1);
        vc_last  = (vc32 == V_TOTAL - 1);
        hc_d     = hc_last ? '0 : hc_q + 1'b1;
        vc_d     = vc_q;
        if (hc_last) begin
            vc_d = vc_last ? '0 : vc_q + 1'b1;
        end
        active_d = (hc32 < H_ACTIVE) && (vc32 < V_ACTIVE);
        hsync_d  = ((hc32 >= HS_BEG) && (hc32 < HS_END)) ? HS_POL : ~HS_POL;
        vsync_d  = ((vc32 >= VS_BEG) && (vc32 < VS_END)) ? VS_POL : ~VS_POL;
        ls_d     = (hc_q == '0);
        fs_d     = ls_d && (vc_q == '0);
        li_d     = ls_d && (vc_q == bus.irq_line);
        fc_d     = (hc_last && vc_last) ? fc_q + 1'b1 : fc_q;
    end

    // Counters and registered outputs; pulses self-clear every clk
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hc_q     <= '0;
            vc_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            active_q <= 1'b0;
            hsync_q  <= ~HS_POL;
            vsync_q  <= ~VS_POL;
            ls_q     <= 1'b0;
            fs_q     <= 1'b0;
            li_q     <= 1'b0;
            fc_q     <= '0;
        end else begin
            ls_q <= 1'b0;
            fs_q <= 1'b0;
            li_q <= 1'b0;
            if (bus.pix_en) begin
                x_q      <= hc_q;
                y_q      <= vc_q;
                active_q <= active_d;
                hsync_q  <= hsync_d;
                vsync_q  <= vsync_d;
                ls_q     <= ls_d;
                fs_q     <= fs_d;
                li_q     <= li_d;
                fc_q     <= fc_d;
                hc_q     <= hc_d;
                vc_q     <= vc_d;
            end
        end
    end

    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.active      = active_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.line_start  = ls_q;
    assign bus.frame_start = fs_q;
    assign bus.line_irq    = li_q;
    assign bus.frame_cnt   = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen in a small 14x7 mode with active-high syncs.
// Expected outputs are queued per clk and compared by a monitor.
module tb_vga_timing_gen;

    localparam int HT  = 14;
    localparam int VT  = 7;
    localparam int HA  = 8;
    localparam int VA  = 4;
    localparam int HS0 = 10;
    localparam int HS1 = 12;
    localparam int VS0 = 5;
    localparam int VS1 = 6;
    localparam int FR  = HT * VT;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       act;
        logic [3:0] x;
        logic [3:0] y;
        logic       ls;
        logic       fs;
        logic       li;
        logic [7:0] fc;
    } exp_t;

    bit   clk = 1'b0;
    logic reset;

    vga_timing_gen_if #(.CW(4), .FW(8)) bus ();

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(4), .FW(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_err    = 0;

    int     m_hc, m_vc;
    exp_t   m_out;
    longint cyc;
    int     n_irq, n_hs, n_vs, n_act, n_ls, n_fs;
    longint fs_t[$];
    longint ls_t[$];

    task automatic chk(input string nm, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Monitor: one queued expectation per clk edge, compared mid-cycle
    always @(negedge clk) begin
        exp_t e, o;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            o = '{hs: bus.hsync, vs: bus.vsync, act: bus.active,
                  x: bus.x, y: bus.y, ls: bus.line_start,
                  fs: bus.frame_start, li: bus.line_irq,
                  fc: bus.frame_cnt};
            n_checks++;
            if (o !== e) begin
                n_err++;
                $display("FAIL sb t=%0t: got x=%0d y=%0d %h expected x=%0d y=%0d %h",
                         $time, o.x, o.y, o, e.x, e.y, e);
            end
        end
    end

    task automatic clr_stats();
        n_irq = 0; n_hs = 0; n_vs = 0; n_act = 0; n_ls = 0; n_fs = 0;
        fs_t.delete();
        ls_t.delete();
    endtask

    // Drive one clk, queue the expected result of its edge
    task automatic step(input bit en);
        bus.pix_en = en;
        if (reset) begin
            m_hc  = 0;
            m_vc  = 0;
            m_out = '0;
        end else begin
            m_out.ls = 1'b0;
            m_out.fs = 1'b0;
            m_out.li = 1'b0;
            if (en) begin
                m_out.x   = 4'(m_hc);
                m_out.y   = 4'(m_vc);
                m_out.act = (m_hc < HA) && (m_vc < VA);
                m_out.hs  = (m_hc >= HS0) && (m_hc < HS1);
                m_out.vs  = (m_vc >= VS0) && (m_vc < VS1);
                m_out.ls  = (m_hc == 0);
                m_out.fs  = (m_hc == 0) && (m_vc == 0);
                m_out.li  = (m_hc == 0) && (m_vc == int'(bus.irq_line));
                if (m_hc == HT - 1 && m_vc == VT - 1)
                    m_out.fc = m_out.fc + 8'd1;
                if (m_hc == HT - 1) begin
                    m_hc = 0;
                    m_vc = (m_vc == VT - 1) ? 0 : m_vc + 1;
                end else begin
                    m_hc = m_hc + 1;
                end
            end
        end
        sb.push_back(m_out);
        @(posedge clk);
        #1;
        cyc++;
        if (bus.line_irq)    n_irq++;
        if (bus.hsync)       n_hs++;
        if (bus.vsync)       n_vs++;
        if (bus.active)      n_act++;
        if (bus.line_start)  begin n_ls++; ls_t.push_back(cyc); end
        if (bus.frame_start) begin n_fs++; fs_t.push_back(cyc); end
    endtask

    initial begin
        int guard;
        cyc          = 0;
        m_hc         = 0;
        m_vc         = 0;
        m_out        = '0;
        reset        = 1'b1;
        bus.pix_en   = 1'b0;
        bus.irq_line = 4'd2;

        repeat (3) step(1'b1);
        chk("reset_x", bus.x, 0);
        chk("reset_hsync", bus.hsync, 0);

        // Continuous pixel tick, two frames
        reset = 1'b0;
        clr_stats();
        step(1'b1);
        chk("first_x", bus.x, 0);
        chk("first_y", bus.y, 0);
        chk("first_active", bus.active, 1);
        chk("first_frame_start", bus.frame_start, 1);
        chk("first_line_start", bus.line_start, 1);
        repeat (2 * FR - 1) step(1'b1);
        chk("hsync_ticks_2fr", n_hs, 2 * 2 * VT);
        chk("vsync_ticks_2fr", n_vs, 2 * HT);
        chk("active_ticks_2fr", n_act, 2 * HA * VA);
        chk("line_irq_2fr", n_irq, 2);
        chk("frame_period", fs_t[1] - fs_t[0], FR);
        chk("line_period", ls_t[1] - ls_t[0], HT);
        chk("frame_cnt_2fr", bus.frame_cnt, 2);

        // Pixel tick every other clk
        clr_stats();
        for (int i = 0; i < 4 * FR; i++) step(i % 2 == 0);
        chk("half_frame_period", fs_t[1] - fs_t[0], 2 * FR);
        chk("half_line_period", ls_t[1] - ls_t[0], 2 * HT);
        chk("half_line_pulses", n_ls, 2 * VT);
        chk("half_hsync_clks", n_hs, 2 * 2 * 2 * VT);

        // Compare line beyond the frame never fires
        bus.irq_line = 4'd9;
        clr_stats();
        repeat (2 * FR) step(1'b1);
        chk("no_irq_line9", n_irq, 0);
        chk("frame_cnt_pre", bus.frame_cnt, 6);

        // Run into hsync inside the vsync line, then reset mid-cycle
        bus.irq_line = 4'd3;
        guard = 0;
        while (!(m_out.x == 4'd11 && m_out.y == 4'd5) && guard < 4 * FR) begin
            step(1'b1);
            guard++;
        end
        chk("reach_vsync_bound", guard < 4 * FR, 1);
        chk("pre_reset_vsync", bus.vsync, 1);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_reset_hsync", bus.hsync, 0);
        chk("mid_reset_vsync", bus.vsync, 0);
        chk("mid_reset_frame_cnt", bus.frame_cnt, 0);
        chk("mid_reset_x", bus.x, 0);
        m_hc  = 0;
        m_vc  = 0;
        m_out = '0;
        repeat (2) step(1'b1);
        reset = 1'b0;
        step(1'b1);
        chk("restart_frame_start", bus.frame_start, 1);
        chk("restart_y", bus.y, 0);

        // Frame counter wrap over 257 frames
        repeat (256 * FR - 1) step(1'b1);
        chk("frame_cnt_256", bus.frame_cnt, 0);
        repeat (FR) step(1'b1);
        chk("frame_cnt_257", bus.frame_cnt, 1);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised raster timing generator producing horizontal/vertical sync, active-video flag, pixel coordinates and frame/line event pulses for any VGA-class mode. All timing is derived from per-interval parameters, so one block covers 640x480@60 (the default) and other modes without RTL edits. A pixel-enable input lets it run from a fast system clock, and a programmable line-compare interrupt supports raster-synchronised game logic. It sits between the clock/reset logic and the pixel renderers; every display consumer takes coordinates and syncs from it.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level (0 = active-low)
CW, 10, coordinate/counter width; must satisfy 2^CW >= max(H_TOTAL, V_TOTAL)
FW, 8, frame counter width

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high
pix_en  input  1  pixel tick; timing advances only on clk edges with pix_en=1
irq_line  input  CW  line number for line_irq compare
hsync  output  1  horizontal sync, polarity HS_POL
vsync  output  1  vertical sync, polarity VS_POL
active  output  1  1 when (x,y) is inside the visible area
x  output  CW  current pixel column, 0..H_TOTAL-1
y  output  CW  current line, 0..V_TOTAL-1
line_start  output  1  one-clk pulse when x=0
frame_start  output  1  one-clk pulse when x=0 and y=0
line_irq  output  1  one-clk pulse when x=0 and y=irq_line
frame_cnt  output  FW  completed-frame count, wraps modulo 2^FW

Behaviour:
- Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 default).
- Internal counters hc, vc. On a pix_en edge: hc wraps from H_TOTAL-1 to 0, else increments. vc increments only when hc wraps; it wraps from V_TOTAL-1 to 0 at the same edge as hc. No off-by-one: a line is exactly H_TOTAL ticks and a frame is exactly H_TOTAL*V_TOTAL ticks.
- Outputs are registered. On a pix_en edge, x, y, active, hsync, vsync and the pulses all take values decoded from the current (hc,vc), then the counters advance. All outputs are therefore mutually coherent, with 1-tick latency from counter to pins.
- active = (hc < H_ACTIVE) && (vc < V_ACTIVE).
- hsync is at level HS_POL when H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC; otherwise it is at ~HS_POL.
- vsync is at level VS_POL when V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC, for whole lines; otherwise it is at ~VS_POL.
- Pulses (line_start, frame_start, line_irq) are high for exactly one clk cycle. They are set on the pix_en edge that presents the qualifying coordinate and cleared on the next clk edge, regardless of pix_en.
- Non-pulse outputs hold their value on clk edges with pix_en=0.
- irq_line is sampled on the pix_en edge with hc=0. If irq_line >= V_TOTAL, line_irq never fires.
- frame_cnt increments on the pix_en edge where hc=H_TOTAL-1 and vc=V_TOTAL-1, and wraps to 0.
- Reset (asynchronous, any time including mid-line or mid-sync):
  - hc, vc, x, y, frame_cnt = 0
  - active = 0
  - hsync = ~HS_POL, vsync = ~VS_POL
  - all pulses = 0
- The first pix_en edge after reset presents x=0, y=0, active=1, and raises line_start and frame_start.
- Elaboration check: fail if H_SYNC, V_SYNC or either ACTIVE value is 0, or if CW is too narrow.

Test Plan:
1. Defaults, pix_en=1 continuously after reset:
   - first edge gives x=0, y=0, frame_start=1, active=1
   - hsync low exactly for x 656..751 (96 ticks)
   - line_start period 800 clk
   - vsync low for y 490..491 (1600 clk)
   - frame_start period 420000 clk
2. Defaults, pix_en every other clk:
   - all periods double (line 1600 clk, frame 840000 clk)
   - pulses still 1 clk wide
   - x/y hold on non-enable clocks
3. irq_line=100: one line_irq per frame, coincident with x=0, y=100. irq_line=600: no line_irq over 2 frames.
4. Small mode H=8/2/2/2, V=4/1/1/1, HS_POL=VS_POL=1, CW=4:
   - x cycles 0..13, y cycles 0..6
   - hsync high for x 10..11, vsync high for y 5
   - active for x<8 and y<4
   - frame = 98 ticks
5. Reset asserted mid-frame at x=700, y=491 (inside vsync): outputs return immediately to reset values (hsync/vsync deasserted, frame_cnt=0); after release the sequence restarts at (0,0) with frame_start.
6. Run 257 frames with FW=8: frame_cnt reads 1 after the 257th frame completes, confirming wrap from 255 to 0.
